// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg
// Shared definitions for the ALU execute unit and the ALU control decoder:
//   - 4-bit ALU control codes (ALU_AND ... ALU_MUL)
//   - execute-unit FSM state enum
//   - shift-kind enum used by the iterative shifter
//   - is_legal_code(): the codes the execute unit actually implements
// Optional feature macro: ALU_EXEC_MUL_EN (adds the MUL state and makes
// ALU_MUL a legal code).
package alu_exec_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef ALU_EXEC_MUL_EN
    ST_MUL   = 2'd3,
`endif
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_t;

  function automatic logic is_legal_code(input logic [3:0] code);
    logic legal;
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR,
      ALU_SLL, ALU_SRL, ALU_SRA: legal = 1'b1;
`ifdef ALU_EXEC_MUL_EN
      ALU_MUL:                   legal = 1'b1;
`endif
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if
// Request/response bundle of the ALU execute unit.
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both 1. The producer holds its payload stable while valid && !ready; the
// consumer may raise or drop ready at any time; valid must not depend on
// ready combinationally.
//   in_valid/in_ready/in_ctrl/in_a/in_b           request channel
//   out_valid/out_ready/out_result/out_zero/out_illegal  response channel
// master: the requester/consumer side; slave: the execute unit.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_ctrl;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_illegal;

  modport master (
    output in_valid, in_ctrl, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, in_ctrl, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_illegal
  );
endinterface

// File: rtl/alu_exec_shifter.sv
// alu_exec_shifter
// Iterative one-bit-per-cycle shift datapath.
//   clk, rst       clock, synchronous active-high reset
//   load           latch load_a / load_shamt / load_kind
//   step_data      value after one more shift step (combinational)
//   last           the step in progress this cycle is the final one
// While the counter is non-zero the stored data shifts by one bit each cycle.
module alu_exec_shifter
  import alu_exec_pkg::*;
#(
  parameter int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_a,
  input  logic [SHAMT_W-1:0] load_shamt,
  input  shift_kind_t        load_kind,
  output logic [WIDTH-1:0]   step_data,
  output logic               last
);

  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] cnt;
  shift_kind_t        kind;

  always_comb begin
    step_data = data;
    case (kind)
      SH_SLL:  step_data = {data[WIDTH-2:0], 1'b0};
      SH_SRL:  step_data = {1'b0, data[WIDTH-1:1]};
      SH_SRA:  step_data = {data[WIDTH-1], data[WIDTH-1:1]};
      default: step_data = data;
    endcase
  end

  assign last = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      cnt  <= '0;
      kind <= SH_SLL;
    end else if (load) begin
      data <= load_a;
      cnt  <= load_shamt;
      kind <= load_kind;
    end else if (cnt != '0) begin
      data <= step_data;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Sequential execute unit for the multi-cycle core: takes a 4-bit ALU control
// code and two operands, returns a registered result with zero/illegal flags.
//   clk, rst     clock, synchronous active-high reset
//   bus          alu_exec_if.slave request/response channels
//   dbg_state    current FSM state
// Logic ops, ADD, SUB, SLT, NOR and illegal codes finish in 1 cycle; shifts
// step one bit per cycle in the alu_exec_shifter sub-module.
// Optional feature macro: ALU_EXEC_MUL_EN adds an unsigned shift-add
// multiplier (code ALU_MUL, WIDTH iterations). Without it, ALU_MUL is illegal.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  bus,
  output state_t     dbg_state
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t             state;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_result_q;
  logic               out_zero_q;
  logic               out_illegal_q;

  logic               xfer;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  shift_kind_t        sh_kind;
  logic               sh_load;
  logic [WIDTH-1:0]   sh_step;
  logic               sh_last;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_illegal;

  // DONE also accepts, so a consumer taking the result can issue the next
  // request in the same cycle.
  assign bus.in_ready    = (state == ST_IDLE) || (state == ST_DONE && bus.out_ready);
  assign xfer            = bus.in_valid && bus.in_ready;
  assign shamt           = bus.in_b[SHAMT_W-1:0];
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_illegal = out_illegal_q;
  assign dbg_state       = state;

  always_comb begin
    is_shift = 1'b0;
    sh_kind  = SH_SLL;
    case (bus.in_ctrl)
      ALU_SLL: begin is_shift = 1'b1; sh_kind = SH_SLL; end
      ALU_SRL: begin is_shift = 1'b1; sh_kind = SH_SRL; end
      ALU_SRA: begin is_shift = 1'b1; sh_kind = SH_SRA; end
      default: begin is_shift = 1'b0; sh_kind = SH_SLL; end
    endcase
  end

  // A zero shift amount never enters SHIFT; it completes like a logic op.
  assign sh_load = xfer && is_shift && (shamt != '0);

  // Single-cycle result; shifts land here only for shamt == 0.
  always_comb begin
    sc_result = '0;
    case (bus.in_ctrl)
      ALU_AND: sc_result = bus.in_a & bus.in_b;
      ALU_OR:  sc_result = bus.in_a | bus.in_b;
      ALU_ADD: sc_result = bus.in_a + bus.in_b;
      ALU_SUB: sc_result = bus.in_a - bus.in_b;
      ALU_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      ALU_NOR: sc_result = ~(bus.in_a | bus.in_b);
      ALU_SLL, ALU_SRL, ALU_SRA: sc_result = bus.in_a;
      default: sc_result = '0;
    endcase
  end

  assign sc_illegal = !is_legal_code(bus.in_ctrl);

  alu_exec_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (sh_load),
    .load_a     (bus.in_a),
    .load_shamt (shamt),
    .load_kind  (sh_kind),
    .step_data  (sh_step),
    .last       (sh_last)
  );

`ifdef ALU_EXEC_MUL_EN
  logic [WIDTH-1:0]   mul_acc;
  logic [WIDTH-1:0]   mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [SHAMT_W-1:0] mul_cnt;
  logic [WIDTH-1:0]   mul_acc_next;

  // Partial product for the current multiplier LSB; the multiplicand is
  // pre-shifted so only the low WIDTH bits are ever kept.
  assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mul_acc       <= '0;
      mul_mcand     <= '0;
      mul_mplier    <= '0;
      mul_cnt       <= '0;
`endif
    end else if (xfer) begin
      if (sh_load) begin
        state         <= ST_SHIFT;
        out_valid_q   <= 1'b0;
        out_illegal_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      end else if (bus.in_ctrl == ALU_MUL) begin
        state         <= ST_MUL;
        out_valid_q   <= 1'b0;
        out_illegal_q <= 1'b0;
        mul_acc       <= '0;
        mul_mcand     <= bus.in_a;
        mul_mplier    <= bus.in_b;
        mul_cnt       <= SHAMT_W'(WIDTH - 1);
`endif
      end else begin
        state         <= ST_DONE;
        out_valid_q   <= 1'b1;
        out_result_q  <= sc_result;
        out_zero_q    <= (sc_result == '0);
        out_illegal_q <= sc_illegal;
      end
    end else begin
      case (state)
        ST_SHIFT: begin
          if (sh_last) begin
            state        <= ST_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= sh_step;
            out_zero_q   <= (sh_step == '0);
          end
        end
`ifdef ALU_EXEC_MUL_EN
        ST_MUL: begin
          mul_acc    <= mul_acc_next;
          mul_mcand  <= {mul_mcand[WIDTH-2:0], 1'b0};
          mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
          mul_cnt    <= mul_cnt - SHAMT_W'(1);
          if (mul_cnt == '0) begin
            state        <= ST_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= mul_acc_next;
            out_zero_q   <= (mul_acc_next == '0);
          end
        end
`endif
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Directed bench for alu_exec_unit (WIDTH=32). Inputs change and outputs are
// sampled on the falling clock edge. Honours ALU_EXEC_MUL_EN for code 1000.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  localparam int WIDTH = 32;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     checks = 0;
  int     errors = 0;
  int     lat;
  int     busy;
  int     seen;

  alu_exec_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns one cycle later with the
  // request withdrawn and operands scrambled.
  task automatic issue(input logic [3:0] ctrl, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_ctrl  = ctrl;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_ctrl  = 4'b1111;
    bus.in_a     = 32'hDEAD_BEEF;
    bus.in_b     = 32'hDEAD_BEEF;
  endtask

  // Latency counted in cycles from the transfer edge; bounded.
  task automatic wait_valid(output int l, output int b);
    l = 1;
    b = 0;
    while (bus.out_valid !== 1'b1 && l < 200) begin
      if (bus.in_ready === 1'b0) b++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctrl,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res, input int exp_lat,
                        input logic exp_ill);
    int l;
    int bz;
    issue(ctrl, a, b);
    wait_valid(l, bz);
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_result"}, bus.out_result, exp_res);
    check({tag, "_zero"}, bus.out_zero, (exp_res == '0));
    check({tag, "_illegal"}, bus.out_illegal, exp_ill);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = 4'b0000;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.out_result, 32'h0);
    check("rst_zero", bus.out_zero, 1'b0);
    check("rst_illegal", bus.out_illegal, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);

    // Single-cycle ops, issued back-to-back while each result is consumed.
    run_op("add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1, 1'b0);
    run_op("sub_zero", ALU_SUB, 32'h1234, 32'h1234, 32'h0, 1, 1'b0);
    run_op("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b0);
    run_op("slt_pos", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1, 1'b0);
    run_op("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, 1'b0);
    run_op("nor", ALU_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 1, 1'b0);

    // SRA by 4: busy for exactly 4 cycles, valid at transfer+5.
    @(negedge clk);
    issue(ALU_SRA, 32'h8000_0000, 32'd4);
    wait_valid(lat, busy);
    check("sra_lat", lat, 5);
    check("sra_busy", busy, 4);
    check("sra_result", bus.out_result, 32'hF800_0000);
    check("sra_illegal", bus.out_illegal, 1'b0);

    // Only the low 5 bits of b are the shift amount: 0x20 means shamt 0.
    run_op("sll_zero", ALU_SLL, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1, 1'b0);
    run_op("srl_31", ALU_SRL, 32'h8000_0000, 32'd31, 32'd1, 32, 1'b0);
    run_op("sll_31", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 32, 1'b0);
    run_op("sll_out", ALU_SLL, 32'h0000_0003, 32'd31, 32'h8000_0000, 32, 1'b0);

    // Backpressure: result held, no new request accepted.
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue(ALU_ADD, 32'd1, 32'd1);
    check("bp_valid0", bus.out_valid, 1'b1);
    check("bp_result0", bus.out_result, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_result", bus.out_result, 32'd2);
      check("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = ALU_OR;
    bus.in_a      = 32'h0000_00F0;
    bus.in_b      = 32'h0000_000F;
    bus.out_ready = 1'b1;
    #1;
    check("bp_accept_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_next_valid", bus.out_valid, 1'b1);
    check("bp_next_result", bus.out_result, 32'h0000_00FF);

    // Illegal codes.
    run_op("ill_1111", 4'b1111, 32'd9, 32'd9, 32'h0, 1, 1'b1);
`ifdef ALU_EXEC_MUL_EN
    run_op("mul", ALU_MUL, 32'd3, 32'd7, 32'd21, WIDTH + 1, 1'b0);
    run_op("mul_wrap", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, WIDTH + 1, 1'b0);
`else
    run_op("ill_mul", ALU_MUL, 32'd3, 32'd7, 32'h0, 1, 1'b1);
`endif
    run_op("and_after_ill", ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1, 1'b0);

    // Reset two cycles into a 10-step SRL.
    @(negedge clk);
    issue(ALU_SRL, 32'hFFFF_0000, 32'd10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_result", bus.out_result, 32'h0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_state", dbg_state, ST_IDLE);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("mid_rst_no_result", seen, 0);
    run_op("or_after_rst", ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Sequential execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands. It returns a registered result, a zero flag and an illegal-op flag.
- Single-cycle ops complete in 1 cycle.
- Shifts iterate one bit per cycle.
- Used by the multi-cycle core variant between operand fetch and writeback.
- valid/ready handshake on both input and output.

Parameters:
WIDTH, 32, operand/result width in bits (power of two, >= 8)
SHAMT_W, $clog2(WIDTH), shift-amount width; derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request this cycle
in_ctrl  input  4  ALU control code
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (shift amount = in_b[SHAMT_W-1:0])
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_zero  output  1  out_result == 0
out_illegal  output  1  in_ctrl was not a supported code

Behaviour:
- Control codes are: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 0011 SLL, 0100 SRL, 0101 SRA, 1000 MUL (optional feature only).
- Any other code is illegal: out_result=0, out_zero=1, out_illegal=1, 1-cycle latency.
- FSM has three states: IDLE, SHIFT, DONE (plus MUL when enabled).
- Request transfer: in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back accept in DONE is allowed.
- Logic ops, ADD, SUB, SLT, NOR and illegal codes:
  - On transfer in cycle N, go to DONE; out_valid=1 in cycle N+1.
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
- Shifts:
  - Latch a, shamt and kind; go to SHIFT.
  - Each cycle shift by 1 (SRA replicates MSB) and decrement the counter.
  - Go to DONE when the counter reaches 0. out_valid is asserted in cycle N+1+shamt.
  - shamt=0 goes directly to DONE (latency 1); result = a.
- DONE:
  - out_result, out_zero and out_illegal are held stable while out_valid && !out_ready.
  - On out_ready: go to IDLE, or accept the new request if in_valid.
- Input operands are sampled only on transfer; later changes are ignored.
- out_zero is computed from the final registered result and is valid only with out_valid.
- Reset (any state, including mid-shift): state=IDLE, out_valid=0, out_result=0, out_zero=0, out_illegal=0, internal counter=0. in_ready=1 from the first cycle after reset deasserts.
- in_valid while busy (SHIFT/MUL): not accepted, no side effects.

Optional Feature:
- Macro: ALU_EXEC_MUL_EN.
- When defined: code 1000 = unsigned shift-add multiply, low WIDTH bits of a*b.
  - One partial product per cycle, WIDTH iterations.
  - Latency WIDTH+1 from transfer to out_valid.
  - Adds state MUL and a WIDTH-bit accumulator.
- When undefined: 1000 is illegal (result 0, out_illegal=1, latency 1); no multiplier logic is instantiated.

Decomposition:
- Package alu_exec_pkg holds:
  - the 4-bit control-code localparams (ALU_AND ... ALU_MUL);
  - the FSM state enum;
  - a function is_legal_code(code).
- Shared with the ALU control decoder so the codes stay consistent.
- One natural sub-module: alu_exec_shifter, the iterative shift datapath (load, step, done), instantiated once.

Test Plan:
- ADD a=5, b=7, out_ready=1 -> out_valid exactly 1 cycle after transfer, result=12, zero=0, illegal=0.
- SUB a=b=0x1234 -> result=0, zero=1. Then SLT a=0xFFFFFFFF, b=1 -> result=1.
- SRA a=0x80000000, shamt=4 -> in_ready=0 for 4 cycles, out_valid at transfer+5, result=0xF8000000. SLL shamt=0 -> latency 1, result=a.
- Backpressure: ADD 1+1, out_ready held low 3 cycles -> result=2 stable, in_ready=0. A new request presented with out_ready=1 is accepted in that same cycle.
- Illegal code 1111 (and 1000 without ALU_EXEC_MUL_EN) -> result=0, zero=1, illegal=1, latency 1.
- rst asserted 2 cycles into SRL shamt=10 -> next cycle out_valid=0, result=0, in_ready=1. A following OR 0xF0|0x0F -> 0xFF. With ALU_EXEC_MUL_EN: MUL 3*7 -> 21 at latency WIDTH+1.
